// File: rtl/cle_key_initiator.sv
// Host-side initiator for the CLE serial key window: issues the unlock nibble
// sequence, then NBITS read strobes capturing SDRD, and compares against a key.
module cle_key_initiator #(
    parameter int          NBITS      = 16,
    parameter int          STROBE_CYC = 2,
    parameter logic [15:0] UNLOCK_SEQ = 16'h28A9,
    parameter logic [3:0]  READ_NIB   = 4'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [NBITS-1:0] expected,
    input  logic             sdrd,
    output logic             sser,
    output logic             ba13,
    output logic             ba12,
    output logic [3:0]       ba_nib,
    output logic             br_w,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [NBITS-1:0] result,
    output logic             match
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, FINISH} state_t;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [5:0] READ_LAST   = 6'(NBITS - 1);

    state_t           state_reg, state_next;
    logic             phase_reg;          // 0: unlock nibbles, 1: data reads
    logic [5:0]       step_reg;
    logic [3:0]       strobe_cnt_reg;
    logic             abort_pend_reg;
    logic [NBITS-1:0] result_reg;
    logic             match_reg;
    logic             aborted_reg;

    logic strobe_last;
    logic unlock_last;
    logic read_last;
    logic abort_now;
    logic [3:0] nib_sel;

    assign strobe_last = (state_reg == STROBE) && (strobe_cnt_reg == STROBE_LAST);
    assign unlock_last = !phase_reg && (step_reg == 6'd3);
    assign read_last   = phase_reg && (step_reg == READ_LAST);
    // An abort seen in SETUP/STROBE is remembered and acted on in RECOVER.
    assign abort_now   = abort || abort_pend_reg;

    always_comb begin
        nib_sel = READ_NIB;
        if (!phase_reg) begin
            case (step_reg[1:0])
                2'd0:    nib_sel = UNLOCK_SEQ[15:12];
                2'd1:    nib_sel = UNLOCK_SEQ[11:8];
                2'd2:    nib_sel = UNLOCK_SEQ[7:4];
                default: nib_sel = UNLOCK_SEQ[3:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   state_next = abort ? RECOVER : STROBE;
            STROBE:  if (abort || strobe_last) state_next = RECOVER;
            RECOVER: begin
                if (abort_now)      state_next = IDLE;
                else if (read_last) state_next = FINISH;
                else                state_next = SETUP;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_reg      <= 1'b0;
            step_reg       <= '0;
            strobe_cnt_reg <= '0;
            abort_pend_reg <= 1'b0;
            result_reg     <= '0;
            match_reg      <= 1'b0;
            aborted_reg    <= 1'b0;
        end else begin
            aborted_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        phase_reg      <= 1'b0;
                        step_reg       <= '0;
                        abort_pend_reg <= 1'b0;
                        result_reg     <= '0;
                        match_reg      <= 1'b0;
                    end
                end
                SETUP: begin
                    strobe_cnt_reg <= '0;
                    if (abort) abort_pend_reg <= 1'b1;
                end
                STROBE: begin
                    strobe_cnt_reg <= strobe_cnt_reg + 4'd1;
                    if (abort) begin
                        abort_pend_reg <= 1'b1;
                    end else if (strobe_last && phase_reg) begin
                        result_reg <= {result_reg[NBITS-2:0], sdrd};
                    end
                end
                RECOVER: begin
                    if (abort_now) begin
                        aborted_reg    <= 1'b1;
                        match_reg      <= 1'b0;
                        abort_pend_reg <= 1'b0;
                    end else if (unlock_last) begin
                        phase_reg  <= 1'b1;
                        step_reg   <= '0;
                        result_reg <= '0;
                    end else begin
                        step_reg <= step_reg + 6'd1;
                        // Final bit is already in result_reg here, so match is valid with done.
                        if (read_last) match_reg <= (result_reg == expected);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sser   = 1'b1;
        ba13   = 1'b0;
        ba12   = 1'b0;
        ba_nib = 4'h0;
        br_w   = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_reg)
            SETUP, STROBE, RECOVER: begin
                ba12   = 1'b1;
                br_w   = 1'b1;
                busy   = 1'b1;
                ba_nib = nib_sel;
                sser   = (state_reg != STROBE);
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    assign aborted = aborted_reg;
    assign result  = result_reg;
    assign match   = match_reg;

endmodule

// File: tb/tb_cle_key_initiator.sv
// Randomized bench for cle_key_initiator: a reference model predicts the nibble
// sequence, captured key, match flag and done latency of each transaction.
module tb_cle_key_initiator;

    localparam int NB  = 16;
    localparam int SC  = 2;
    localparam int LAT = (4 + NB) * (SC + 2) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NB-1:0] expected = '0;
    logic          sdrd = 1'b0;
    logic          sser, ba13, ba12, br_w, busy, done, aborted, match;
    logic [3:0]    ba_nib;
    logic [NB-1:0] result;

    int            vectors = 0;
    int            miscompares = 0;
    int            done_cnt = 0;
    int            aborted_cnt = 0;
    logic [3:0]    nib_q[$];
    logic [NB-1:0] cur_key = '0;
    logic          prev_sser = 1'b1;
    logic [3:0]    held_nib = 4'h0;

    cle_key_initiator #(.NBITS(NB), .STROBE_CYC(SC),
                        .UNLOCK_SEQ(16'h28A9), .READ_NIB(4'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected(expected), .sdrd(sdrd), .sser(sser), .ba13(ba13),
        .ba12(ba12), .ba_nib(ba_nib), .br_w(br_w), .busy(busy),
        .done(done), .aborted(aborted), .result(result), .match(match)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_nib(input int i);
        logic [15:0] seq;
        seq = 16'h28A9;
        if (i < 4) return 4'((seq >> (12 - 4 * i)) & 16'hF);
        return 4'h0;
    endfunction

    // Bus monitor: records the nibble of each strobe, plays the key onto sdrd.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (aborted) aborted_cnt++;
        if (!sser) begin
            if (!prev_sser) begin
                chk("addr_stable", 32'(ba_nib), 32'(held_nib));
            end else begin
                int idx;
                held_nib = ba_nib;
                nib_q.push_back(ba_nib);
                chk("strobe_ctl", 32'({ba13, ba12, br_w}), 32'(3'b011));
                idx = nib_q.size() - 5;
                if (idx >= 0 && idx < NB) sdrd = cur_key[NB-1-idx];
                else sdrd = 1'($urandom);
            end
        end
        prev_sser = sser;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, 32'({sser, ba13, ba12, ba_nib, br_w, busy, done, aborted, match}),
            32'({1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        chk({tag, "_result"}, 32'(result), 32'h0);
    endtask

    task automatic run_txn(input logic [NB-1:0] key, input logic [NB-1:0] exp,
                           input int restart_at, input bit do_abort);
        int cycles;
        nib_q.delete();
        done_cnt    = 0;
        aborted_cnt = 0;
        cur_key     = key;
        expected    = exp;
        idle(1);
        start = 1'b1;
        idle(1);
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < LAT + 20) begin
            start = (cycles == restart_at);
            if (do_abort && !sser && nib_q.size() == 7) begin
                abort = 1'b1;
                idle(1);
                abort = 1'b0;
                chk("sser_after_abort", 32'(sser), 32'h1);
                chk("aborted_early", 32'(aborted), 32'h0);
                idle(1);
                chk("aborted_pulse", 32'(aborted), 32'h1);
                chk("busy_after_abort", 32'(busy), 32'h0);
                chk("match_after_abort", 32'(match), 32'h0);
                idle(LAT);
                chk("no_done_on_abort", 32'(done_cnt), 32'h0);
                chk("aborted_once", 32'(aborted_cnt), 32'h1);
                return;
            end
            idle(1);
            cycles++;
        end
        start = 1'b0;
        chk("latency", 32'(cycles), 32'(LAT));
        chk("result", 32'(result), 32'(key));
        chk("match", 32'(match), 32'(key == exp));
        chk("busy_at_done", 32'(busy), 32'h0);
        chk("nib_count", 32'(nib_q.size()), 32'(4 + NB));
        for (int i = 0; i < nib_q.size() && i < 4 + NB; i++)
            chk($sformatf("nib%0d", i), 32'(nib_q[i]), 32'(model_nib(i)));
        idle(5);
        chk("done_once", 32'(done_cnt), 32'h1);
        chk("result_hold", 32'(result), 32'(key));
        chk("match_hold", 32'(match), 32'(key == exp));
        chk("idle_sser", 32'(sser), 32'h1);
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(10);
        check_reset_outputs("reset_idle");

        run_txn(16'hA5C3, 16'hA5C3, -1, 1'b0);
        run_txn(16'hA5C3, 16'hA5C2, -1, 1'b0);
        run_txn(16'h5A3C, 16'h5A3C, -1, 1'b1);
        run_txn(16'h1234, 16'h1234, 40, 1'b0);

        // Reset in the middle of the unlock sequence.
        nib_q.delete();
        done_cnt    = 0;
        aborted_cnt = 0;
        start = 1'b1;
        idle(1);
        start  = 1'b0;
        waited = 0;
        while (nib_q.size() < 3 && waited < 50) begin
            idle(1);
            waited++;
        end
        chk("reach_unlock2", 32'(nib_q.size()), 32'h3);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check_reset_outputs("mid_reset");
        idle(LAT);
        chk("reset_no_done", 32'(done_cnt), 32'h0);
        chk("reset_no_abort", 32'(aborted_cnt), 32'h0);

        for (int t = 0; t < 8; t++) begin
            logic [NB-1:0] key, exp;
            key = NB'($urandom);
            exp = ($urandom_range(0, 1) == 1) ? key : key ^ NB'(1 << $urandom_range(0, NB - 1));
            run_txn(key, exp, (t == 5) ? 20 : -1, t == 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
